// File: rtl/dsram_bridge_pkg.sv
// Shared definitions for the data-SRAM bridge: FSM state encodings,
// bus transfer size codes and the write-enable to size decode.
package dsram_bridge_pkg;

  typedef enum logic [1:0] {
    DSB_IDLE = 2'd0,
    DSB_ADDR = 2'd1,
    DSB_DATA = 2'd2,
    DSB_DONE = 2'd3
  } dsb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Reads (no strobes) and full-word writes are word transfers; the two
  // aligned halves are half transfers; anything else is treated as a byte.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b0000, 4'b1111: size = SIZE_WORD;
      4'b0011, 4'b1100: size = SIZE_HALF;
      default:          size = SIZE_BYTE;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/dsram_bridge.sv
// Bridge from the core's synchronous data-SRAM port to a variable-latency
// SRAM-like bus (req/addr_ok/data_ok). One bus access is issued per core
// request; stallreq holds the pipeline until data_ok, and read data is
// registered so the MEM stage sees it stable after the stall releases.
//
// Ports:
//   clk, rst            core clock; asynchronous active-low reset
//   data_sram_en/wen/addr/wdata   core request (held while stalled)
//   data_sram_rdata     registered read data to MEM
//   stallreq            stall request to CTRL
//   bus_req/wr/size/wstrb/addr/wdata   bus request side (regs stable during req)
//   bus_addr_ok/data_ok/rdata          bus response side
module dsram_bridge
  import dsram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_sram_en,
  input  logic [DATA_W/8-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic [DATA_W-1:0]   data_sram_rdata,
  output logic                stallreq,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  dsb_state_e state_reg;
  dsb_state_e state_next;
  logic       start_access;
  logic       read_done;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= DSB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. data_ok is only honoured once addr_ok has been seen
  // (same cycle or later); in DONE the still-asserted en belongs to the
  // access just finished, so it is not reissued.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DSB_IDLE: if (data_sram_en) state_next = DSB_ADDR;
      DSB_ADDR: begin
        if (bus_addr_ok && bus_data_ok) state_next = DSB_DONE;
        else if (bus_addr_ok)           state_next = DSB_DATA;
      end
      DSB_DATA: if (bus_data_ok) state_next = DSB_DONE;
      DSB_DONE: state_next = DSB_IDLE;
      default:  state_next = DSB_IDLE;
    endcase
  end

  // Outputs. stallreq rises in the same cycle en is seen in IDLE so the
  // pipeline freezes before the request is even on the bus; it is masked by
  // reset so all outputs read zero while rst is low.
  always_comb begin
    stallreq = 1'b0;
    bus_req  = 1'b0;
    case (state_reg)
      DSB_IDLE: stallreq = data_sram_en;
      DSB_ADDR: begin
        stallreq = 1'b1;
        bus_req  = 1'b1;
      end
      DSB_DATA: stallreq = 1'b1;
      default:  stallreq = 1'b0;
    endcase
    stallreq = stallreq & rst;
  end

  assign start_access = (state_reg == DSB_IDLE) && data_sram_en;
  assign read_done    = !bus_wr && bus_data_ok &&
                        (((state_reg == DSB_ADDR) && bus_addr_ok) ||
                         (state_reg == DSB_DATA));

  // Request registers load only when leaving IDLE, so they cannot move while
  // bus_req is high. Read data is captured only on a read completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_wr          <= 1'b0;
      bus_size        <= SIZE_BYTE;
      bus_wstrb       <= '0;
      bus_addr        <= '0;
      bus_wdata       <= '0;
      data_sram_rdata <= '0;
    end else begin
      if (start_access) begin
        bus_wr    <= |data_sram_wen;
        bus_size  <= wen_to_size(data_sram_wen);
        bus_wstrb <= data_sram_wen;
        bus_addr  <= data_sram_addr;
        bus_wdata <= data_sram_wdata;
      end
      if (read_done) begin
        data_sram_rdata <= bus_rdata;
      end
    end
  end

endmodule
